// File: rtl/i2s_pkg.sv
// i2s_pkg: constants and helpers shared by the I2S/TDM receive master and its frame generator.
package i2s_pkg;
    typedef enum logic {I2S_WS = 1'b0, TDM_FSYNC = 1'b1} ws_mode_e;
    localparam int DLY_I2S = 1;
    localparam int DLY_LJ = 0;
    function automatic int ctr_width(input int num_ch, input int slot_width);
        return $clog2(num_ch * slot_width);
    endfunction
    function automatic ws_mode_e ws_mode(input int num_ch);
        return num_ch == 2 ? I2S_WS : TDM_FSYNC;
    endfunction
endpackage

// File: rtl/i2s_tdm_rx_if.sv
// i2s_tdm_rx_if: received-word stream (data plus slot tag) with valid/ready handshake.
interface i2s_tdm_rx_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH = 2
);
    localparam int CH_W = $clog2(NUM_CH);
    logic [DATA_WIDTH-1:0] o_data;
    logic [CH_W-1:0] o_ch;
    logic o_vld;
    logic i_rdy;
    modport master(output o_data, o_ch, o_vld, input i_rdy);
    modport slave(input o_data, o_ch, o_vld, output i_rdy);
endinterface

// File: rtl/i2s_frame_gen.sv
// i2s_frame_gen: frame counter, WS/frame-sync strobe and the delayed capture position (slot, bit).
module i2s_frame_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_WIDTH = 16,
    parameter int NUM_CH = 2,
    parameter int DATA_DELAY = DLY_I2S,
    localparam int BW = $clog2(SLOT_WIDTH),
    localparam int CH_W = $clog2(NUM_CH)
) (
    input  logic i_sck,
    input  logic i_sys_rst_n,
    input  logic i_en,
    output logic act,
    output logic [BW-1:0] cap_bit,
    output logic [CH_W-1:0] cap_slot,
    output logic o_ws
);
    localparam int CW = ctr_width(NUM_CH, SLOT_WIDTH);
    localparam ws_mode_e MODE = ws_mode(NUM_CH);
    localparam logic [CW-1:0] P_LAST = CW'(NUM_CH * SLOT_WIDTH - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(SLOT_WIDTH - 1);
    localparam logic [CH_W-1:0] SLOT_LAST = CH_W'(NUM_CH - 1);
    // the capture position trails p by DATA_DELAY, so at p=0 it sits at F-DATA_DELAY
    localparam logic [BW-1:0] BIT_INIT = DATA_DELAY == DLY_LJ ? '0 : BIT_LAST;
    localparam logic [CH_W-1:0] SLOT_INIT = DATA_DELAY == DLY_LJ ? '0 : SLOT_LAST;
    logic run;
    logic [CW-1:0] p, p_nxt;
    logic [BW-1:0] bit_nxt;
    logic [CH_W-1:0] slot_nxt;
    assign act = i_en & run;
    always_comb begin
        p_nxt = !act ? '0 : (p == P_LAST ? '0 : p + 1'b1);
        bit_nxt = !act ? BIT_INIT : (cap_bit == BIT_LAST ? '0 : cap_bit + 1'b1);
        slot_nxt = !act ? SLOT_INIT :
                   (cap_bit != BIT_LAST ? cap_slot : (cap_slot == SLOT_LAST ? '0 : cap_slot + 1'b1));
    end
    always_ff @(posedge i_sck or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            run <= 1'b0;
            p <= '0;
            cap_bit <= BIT_INIT;
            cap_slot <= SLOT_INIT;
            o_ws <= 1'b0;
        end else begin
            run <= i_en;
            p <= p_nxt;
            cap_bit <= bit_nxt;
            cap_slot <= slot_nxt;
            o_ws <= i_en & (MODE == I2S_WS ? p_nxt >= CW'(SLOT_WIDTH) : p_nxt == '0);
        end
    end
endmodule

// File: rtl/i2s_tdm_rx.sv
// i2s_tdm_rx: I2S/TDM receive master; deserialises each slot into a tagged valid/ready word stream.
// Define I2S_RX_OVR_CNT_EN to build the saturating 16-bit overrun counter on o_ovr_cnt.
module i2s_tdm_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 16,
    parameter int NUM_CH = 2,
    parameter int DATA_DELAY = DLY_I2S
) (
    input  logic i_sck,
    input  logic i_sys_rst_n,
    input  logic i_en,
    input  logic i_sd,
    output logic o_ws,
    output logic o_overrun,
    output logic [15:0] o_ovr_cnt,
    i2s_tdm_rx_if.master bus
);
    localparam int BW = $clog2(SLOT_WIDTH);
    localparam int CH_W = $clog2(NUM_CH);
    logic act, cap, first, last, load, armed, ovr_nxt;
    logic [BW-1:0] cap_bit;
    logic [CH_W-1:0] cap_slot;
    logic [DATA_WIDTH-1:0] shift, word;
    i2s_frame_gen #(
        .SLOT_WIDTH(SLOT_WIDTH),
        .NUM_CH(NUM_CH),
        .DATA_DELAY(DATA_DELAY)
    ) u_frame (
        .i_sck(i_sck),
        .i_sys_rst_n(i_sys_rst_n),
        .i_en(i_en),
        .act(act),
        .cap_bit(cap_bit),
        .cap_slot(cap_slot),
        .o_ws(o_ws)
    );
    // armed gates the load so a slot whose MSB was not seen since (re)start never reaches the output
    always_comb begin
        cap = act & (int'(cap_bit) < DATA_WIDTH);
        first = cap & (cap_bit == '0);
        last = cap & (int'(cap_bit) == DATA_WIDTH - 1);
        load = last & armed;
        word = {shift[DATA_WIDTH-2:0], i_sd};
        ovr_nxt = load & bus.o_vld & !bus.i_rdy;
    end
    always_ff @(posedge i_sck or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            shift <= '0;
            armed <= 1'b0;
            o_overrun <= 1'b0;
            bus.o_vld <= 1'b0;
            bus.o_data <= '0;
            bus.o_ch <= '0;
        end else begin
            shift <= !i_en ? '0 : (cap ? word : shift);
            armed <= act & (armed | first);
            o_overrun <= ovr_nxt;
            bus.o_vld <= load | (bus.o_vld & !bus.i_rdy);
            bus.o_data <= load ? word : bus.o_data;
            bus.o_ch <= load ? cap_slot : bus.o_ch;
        end
    end
`ifdef I2S_RX_OVR_CNT_EN
    always_ff @(posedge i_sck or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n)
            o_ovr_cnt <= '0;
        else if (ovr_nxt && o_ovr_cnt != 16'hFFFF)
            o_ovr_cnt <= o_ovr_cnt + 16'd1;
    end
`else
    assign o_ovr_cnt = '0;
`endif
endmodule

// File: tb/tb_i2s_tdm_rx.sv
// tb_i2s_tdm_rx: directed table-driven bench for i2s_tdm_rx in I2S, TDM-8 and left-justified setups.
module tb_i2s_tdm_rx;
    typedef struct {
        logic [31:0] sd;
        logic [23:0] exp;
    } vec_t;
`ifdef I2S_RX_OVR_CNT_EN
    localparam logic [15:0] OVR_EXP = 16'd1;
`else
    localparam logic [15:0] OVR_EXP = 16'd0;
`endif
    logic clk = 1'b0;
    logic rst_n;
    logic [2:0] en, sd, rdy, ws, ovr;
    logic [2:0] vld;
    logic [2:0][31:0] d;
    logic [2:0][3:0] ch;
    logic [2:0][15:0] cnt;
    vec_t tbl [16];
    int checks = 0;
    int errors = 0;
    int npulse;

    always #5 clk = ~clk;

    i2s_tdm_rx_if #(.DATA_WIDTH(16), .NUM_CH(2)) bus0 ();
    i2s_tdm_rx_if #(.DATA_WIDTH(24), .NUM_CH(8)) bus1 ();
    i2s_tdm_rx_if #(.DATA_WIDTH(16), .NUM_CH(2)) bus2 ();

    i2s_tdm_rx u0 (.i_sck(clk), .i_sys_rst_n(rst_n), .i_en(en[0]), .i_sd(sd[0]), .o_ws(ws[0]),
                   .o_overrun(ovr[0]), .o_ovr_cnt(cnt[0]), .bus(bus0));
    i2s_tdm_rx #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .NUM_CH(8), .DATA_DELAY(1)) u1 (
                   .i_sck(clk), .i_sys_rst_n(rst_n), .i_en(en[1]), .i_sd(sd[1]), .o_ws(ws[1]),
                   .o_overrun(ovr[1]), .o_ovr_cnt(cnt[1]), .bus(bus1));
    i2s_tdm_rx #(.DATA_WIDTH(16), .SLOT_WIDTH(16), .NUM_CH(2), .DATA_DELAY(0)) u2 (
                   .i_sck(clk), .i_sys_rst_n(rst_n), .i_en(en[2]), .i_sd(sd[2]), .o_ws(ws[2]),
                   .o_overrun(ovr[2]), .o_ovr_cnt(cnt[2]), .bus(bus2));

    assign bus0.i_rdy = rdy[0];
    assign bus1.i_rdy = rdy[1];
    assign bus2.i_rdy = rdy[2];
    assign vld = {bus2.o_vld, bus1.o_vld, bus0.o_vld};
    assign d[0] = 32'(bus0.o_data);
    assign d[1] = 32'(bus1.o_data);
    assign d[2] = 32'(bus2.o_data);
    assign ch[0] = 4'(bus0.o_ch);
    assign ch[1] = 4'(bus1.o_ch);
    assign ch[2] = 4'(bus2.o_ch);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // slave model: slot words are sw bits, MSB first, starting dd cycles after the slot boundary
    function automatic logic sd_bit(input int bp, input int sw, input int dd, input int n);
        int off, idx;
        off = bp - dd;
        if (off < 0) return 1'b0;
        idx = off / sw;
        if (idx >= n) return 1'b0;
        return tbl[idx].sd[sw - 1 - (off % sw)];
    endfunction

    // bp counts cycles from frame start (p=0); the caller arms en (or releases reset) one negedge before
    task automatic run_stream(input int u, input int sw, input int dw, input int nc, input int dd,
                              input int n, input int last);
        for (int bp = 0; bp <= last; bp++) begin
            int ev, ei;
            @(negedge clk);
            ev = 0;
            ei = 0;
            for (int i = 0; i < n; i++)
                if (bp == i * sw + dw + dd) begin
                    ev = 1;
                    ei = i;
                end
            check($sformatf("u%0d vld bp%0d", u, bp), 32'(vld[u]), 32'(ev));
            if (ev != 0) begin
                check($sformatf("u%0d data bp%0d", u, bp), d[u], 32'(tbl[ei].exp));
                check($sformatf("u%0d ch bp%0d", u, bp), 32'(ch[u]), 32'(ei % nc));
            end
            check($sformatf("u%0d ws bp%0d", u, bp), 32'(ws[u]),
                  32'((nc == 2) ? ((bp % (nc * sw)) >= sw) : ((bp % (nc * sw)) == 0)));
            check($sformatf("u%0d ovr bp%0d", u, bp), 32'(ovr[u]), 32'd0);
            sd[u] = sd_bit(bp, sw, dd, n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = '0;
        sd = '0;
        rdy = '1;
        repeat (3) @(negedge clk);
        check("rst ws", 32'(ws[0]), 32'd0);
        check("rst data", d[0], 32'd0);
        check("rst ch", 32'(ch[0]), 32'd0);
        check("rst vld", 32'(vld[0]), 32'd0);
        check("rst ovr", 32'(ovr[0]), 32'd0);
        check("rst cnt", 32'(cnt[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{32'h0000A5C3, 24'hA5C3};
        tbl[1] = '{32'h00001234, 24'h1234};
        tbl[2] = '{32'h0000FFFF, 24'hFFFF};
        tbl[3] = '{32'h00000000, 24'h0000};
        tbl[4] = '{32'h00008001, 24'h8001};
        tbl[5] = '{32'h00007FFE, 24'h7FFE};
        @(negedge clk);
        en[0] = 1'b1;
        run_stream(0, 16, 16, 2, 1, 6, 99);
        en[0] = 1'b0;
        sd[0] = 1'b0;

        for (int k = 0; k < 9; k++) begin
            tbl[k].exp = 24'((k << 16) | k);
            tbl[k].sd = {tbl[k].exp, 8'h5A ^ 8'(k)};
        end
        @(negedge clk);
        en[1] = 1'b1;
        run_stream(1, 32, 24, 8, 1, 9, 283);
        en[1] = 1'b0;
        sd[1] = 1'b0;

        tbl[0] = '{32'h00008001, 24'h8001};
        tbl[1] = '{32'h00004002, 24'h4002};
        @(negedge clk);
        en[2] = 1'b1;
        run_stream(2, 16, 16, 2, 0, 2, 34);
        en[2] = 1'b0;
        sd[2] = 1'b0;

        tbl[0] = '{32'h00001111, 24'h1111};
        tbl[1] = '{32'h00002222, 24'h2222};
        npulse = 0;
        @(negedge clk);
        rdy[0] = 1'b0;
        en[0] = 1'b1;
        for (int bp = 0; bp <= 40; bp++) begin
            @(negedge clk);
            npulse += int'(ovr[0]);
            if (bp == 17) begin
                check("ovr first vld", 32'(vld[0]), 32'd1);
                check("ovr first data", d[0], 32'h1111);
                check("ovr first ch", 32'(ch[0]), 32'd0);
                check("ovr first pulse", 32'(ovr[0]), 32'd0);
            end
            if (bp == 33) begin
                check("ovr pulse", 32'(ovr[0]), 32'd1);
                check("ovr new data", d[0], 32'h2222);
                check("ovr new ch", 32'(ch[0]), 32'd1);
            end
            if (bp == 34) begin
                check("ovr pulse width", 32'(ovr[0]), 32'd0);
                check("ovr held vld", 32'(vld[0]), 32'd1);
                check("ovr cnt", 32'(cnt[0]), 32'(OVR_EXP));
            end
            sd[0] = sd_bit(bp, 16, 1, 2);
        end
        en[0] = 1'b0;
        sd[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("ovr hold vld en0", 32'(vld[0]), 32'd1);
        check("ovr hold data en0", d[0], 32'h2222);
        check("ovr hold ch en0", 32'(ch[0]), 32'd1);
        check("ovr ws en0", 32'(ws[0]), 32'd0);
        check("ovr pulse count", 32'(npulse), 32'd1);
        rdy[0] = 1'b1;
        @(negedge clk);
        check("ovr accepted", 32'(vld[0]), 32'd0);

        tbl[0] = '{32'h0000DEAD, 24'hDEAD};
        @(negedge clk);
        en[0] = 1'b1;
        run_stream(0, 16, 16, 2, 1, 1, 9);
        en[0] = 1'b0;
        sd[0] = 1'b0;
        tbl[0] = '{32'h0000BEEF, 24'hBEEF};
        tbl[1] = '{32'h00000F0F, 24'h0F0F};
        repeat (4) begin
            @(negedge clk);
            check("en0 ws", 32'(ws[0]), 32'd0);
            check("en0 vld", 32'(vld[0]), 32'd0);
        end
        @(negedge clk);
        en[0] = 1'b1;
        run_stream(0, 16, 16, 2, 1, 2, 35);
        en[0] = 1'b0;
        sd[0] = 1'b0;

        tbl[0] = '{32'h0000A5C3, 24'hA5C3};
        tbl[1] = '{32'h00001234, 24'h1234};
        @(negedge clk);
        en[0] = 1'b1;
        run_stream(0, 16, 16, 2, 1, 2, 20);
        rst_n = 1'b0;
        #1;
        check("midrst ws", 32'(ws[0]), 32'd0);
        check("midrst data", d[0], 32'd0);
        check("midrst ch", 32'(ch[0]), 32'd0);
        check("midrst vld", 32'(vld[0]), 32'd0);
        check("midrst ovr", 32'(ovr[0]), 32'd0);
        check("midrst cnt", 32'(cnt[0]), 32'd0);
        @(negedge clk);
        sd[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_stream(0, 16, 16, 2, 1, 2, 35);
        en[0] = 1'b0;
        sd[0] = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
